// File: rtl/spi_share_arbiter.sv
// rtl/spi_share_arbiter.sv - round-robin owner arbiter for a shared AD9361 SPI bus
module spi_share_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic               bus_clk,
   input  logic               bus_rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   input  logic [NUM_REQ-1:0] sen_in,
   input  logic [NUM_REQ-1:0] sclk_in,
   input  logic [NUM_REQ-1:0] mosi_in,
   output logic [NUM_REQ-1:0] miso_out,
   output logic               spi_sen,
   output logic               spi_sclk,
   output logic               spi_mosi,
   input  logic               spi_miso,
   output logic [2:0]         owner,
   output logic               busy,
   output logic               timeout_stb
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [NUM_REQ-1:0] lockout_q, lockout_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               tmo_q, tmo_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] lock_set;
   logic               release_ok;
   logic               wd_hit;
   logic [IDX_W-1:0]   rr_after_owner;
   int                 cand;

   // State and bookkeeping registers; reset returns the bus to idle immediately
   always_ff @(posedge bus_clk) begin
      if (bus_rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         lockout_q <= '0;
         wd_q      <= '0;
         gap_q     <= '0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         lockout_q <= lockout_d;
         wd_q      <= wd_d;
         gap_q     <= gap_d;
         tmo_q     <= tmo_d;
      end
   end

   // Next-state: round-robin pick in IDLE, release/watchdog in GRANT, idle gap countdown
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      wd_d       = wd_q;
      gap_d      = gap_q;
      tmo_d      = 1'b0;
      lock_set   = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;

      // First eligible requester at or after rr, wrapping
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!pick_found && req[cand] && !lockout_q[cand]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end

      // A frame in progress (sen low) keeps the grant even after req drops
      release_ok     = !req[owner_q] && sen_in[owner_q];
      wd_hit         = (TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
      rr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d           = S_GRANT;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
               owner_d           = pick_idx;
               wd_d              = '0;
            end
         end
         S_GRANT: begin
            if (release_ok || wd_hit) begin
               gnt_d = '0;
               rr_d  = rr_after_owner;
               if (!release_ok) begin
                  tmo_d             = 1'b1;
                  lock_set[owner_q] = 1'b1;
               end
               if (GAP_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAP_W'(GAP_CYCLES - 1);
               end
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_IDLE;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase

      // A timed-out master stays locked out until it lowers its request once
      lockout_d = (lockout_q | lock_set) & req;
   end

   // Outputs: owner's pins mirrored while granted, idle levels otherwise
   always_comb begin
      spi_sen  = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      if (state_q == S_GRANT) begin
         spi_sen  = sen_in[owner_q];
         spi_sclk = sclk_in[owner_q];
         spi_mosi = mosi_in[owner_q];
      end
      miso_out    = {NUM_REQ{spi_miso}};
      busy        = (state_q != S_IDLE);
      gnt         = gnt_q;
      owner       = 3'(owner_q);
      timeout_stb = tmo_q;
   end

endmodule

// File: tb/tb_spi_share_arbiter.sv
// tb/tb_spi_share_arbiter.sv - directed and randomized checks of spi_share_arbiter
module tb_spi_share_arbiter;

   localparam int N   = 2;
   localparam int GAP = 4;
   localparam int TO  = 32;

   logic         bus_clk = 1'b0;
   logic         bus_rst;
   logic [N-1:0] req, gnt, sen_in, sclk_in, mosi_in, miso_out;
   logic         spi_sen, spi_sclk, spi_mosi, spi_miso;
   logic [2:0]   owner;
   logic         busy, timeout_stb;

   int total = 0;
   int bad   = 0;
   int rr_m  = 0;

   spi_share_arbiter #(
      .NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .bus_clk(bus_clk), .bus_rst(bus_rst), .req(req), .gnt(gnt),
      .sen_in(sen_in), .sclk_in(sclk_in), .mosi_in(mosi_in), .miso_out(miso_out),
      .spi_sen(spi_sen), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .owner(owner), .busy(busy), .timeout_stb(timeout_stb)
   );

   always #5 bus_clk = ~bus_clk;

   initial begin
      #2000000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge bus_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Spec rule: first requester with no lockout at or after the pointer, wrapping
   function automatic int pick(input logic [N-1:0] r, input logic [N-1:0] lk, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (r[i] && !lk[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      bus_rst  = 1'b1;
      req      = '0;
      sen_in   = '1;
      sclk_in  = '0;
      mosi_in  = '0;
      spi_miso = 1'b0;
      tick();
      tick();
      bus_rst  = 1'b0;
      rr_m     = 0;
   endtask

   // Owner m clocks n bits; shared pins must follow m with zero skew
   task automatic run_txn(input int m, input int n);
      for (int b = 0; b < n; b++) begin
         sclk_in  = N'($urandom);
         mosi_in  = N'($urandom);
         sen_in   = N'($urandom);
         sen_in[m] = 1'b0;
         spi_miso = 1'($urandom);
         #1;
         chk("txn_sen",  32'(spi_sen),  32'(0));
         chk("txn_sclk", 32'(spi_sclk), 32'(sclk_in[m]));
         chk("txn_mosi", 32'(spi_mosi), 32'(mosi_in[m]));
         chk("miso_fan", 32'(miso_out), 32'({N{spi_miso}}));
         tick();
      end
   endtask

   task automatic do_release(input int m);
      req[m]    = 1'b0;
      sen_in[m] = 1'b1;
      sclk_in   = N'($urandom);
      mosi_in   = N'($urandom);
      tick();
      chk("rel_gnt",  32'(gnt), 32'(0));
      chk("rel_busy", 32'(busy), 32'(1));
      chk("rel_tmo",  32'(timeout_stb), 32'(0));
      chk("rel_sen",  32'(spi_sen), 32'(1));
      chk("rel_sclk", 32'(spi_sclk), 32'(0));
      chk("rel_mosi", 32'(spi_mosi), 32'(0));
      rr_m = (m + 1) % N;
   endtask

   // Called one tick after gnt fell: GAP idle cycles, then the expected grant
   task automatic gap_then_grant(input logic [N-1:0] e);
      for (int i = 1; i <= GAP + 1; i++) begin
         tick();
         chk("gap_tmo", 32'(timeout_stb), 32'(0));
         if (i <= GAP) begin
            chk("gap_gnt",  32'(gnt), 32'(0));
            chk("gap_busy", 32'(busy), 32'(i < GAP));
            chk("gap_sen",  32'(spi_sen), 32'(1));
         end else begin
            chk("gap_next_gnt",  32'(gnt), 32'(e));
            chk("gap_next_busy", 32'(busy), 32'(e != 0));
         end
      end
   endtask

   initial begin
      int exp_o, prev, len;
      logic [N-1:0] mask;

      // Reset values
      do_reset();
      chk("rst_gnt",   32'(gnt), 32'(0));
      chk("rst_owner", 32'(owner), 32'(0));
      chk("rst_busy",  32'(busy), 32'(0));
      chk("rst_tmo",   32'(timeout_stb), 32'(0));
      chk("rst_sen",   32'(spi_sen), 32'(1));
      chk("rst_sclk",  32'(spi_sclk), 32'(0));
      chk("rst_mosi",  32'(spi_mosi), 32'(0));

      // Single request with a 16-bit frame
      req = 2'b01;
      tick();
      chk("single_gnt",   32'(gnt), 32'(2'b01));
      chk("single_owner", 32'(owner), 32'(0));
      chk("single_busy",  32'(busy), 32'(1));
      run_txn(0, 16);
      do_release(0);
      gap_then_grant('0);

      // Simultaneous requests from reset, then continuous-request fairness
      do_reset();
      req  = 2'b11;
      prev = -1;
      exp_o = pick(req, '0, rr_m);
      tick();
      for (int t = 0; t < 6; t++) begin
         chk("fair_gnt",   32'(gnt), 32'(oh(exp_o)));
         chk("fair_owner", 32'(owner), 32'(exp_o));
         chk("fair_alt",   32'(int'(owner) != prev), 32'(1));
         prev = exp_o;
         run_txn(exp_o, $urandom_range(3, 12));
         do_release(exp_o);
         if (t < 5) begin
            req[prev] = 1'b1;
            exp_o = pick(2'b11, '0, rr_m);
            gap_then_grant(oh(exp_o));
         end else begin
            req = '0;
            gap_then_grant('0);
         end
      end

      // Randomized request masks from idle against the round-robin model
      for (int r = 0; r < 10; r++) begin
         mask  = N'($urandom_range(1, 3));
         req   = mask;
         sen_in = '1;
         exp_o = pick(mask, '0, rr_m);
         tick();
         chk("rand_gnt",   32'(gnt), 32'(oh(exp_o)));
         chk("rand_owner", 32'(owner), 32'(exp_o));
         run_txn(exp_o, $urandom_range(1, 10));
         req = '0;
         do_release(exp_o);
         gap_then_grant('0);
      end

      // Request dropped mid-frame: grant held until sen rises
      do_reset();
      req = 2'b10;
      tick();
      chk("early_gnt", 32'(gnt), 32'(2'b10));
      run_txn(1, 4);
      req[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sen_in[1] = 1'b0;
         #1;
         chk("early_sen_low", 32'(spi_sen), 32'(0));
         tick();
         chk("early_hold", 32'(gnt), 32'(2'b10));
      end
      sen_in[1] = 1'b1;
      #1;
      chk("early_sen_up", 32'(spi_sen), 32'(1));
      chk("early_still",  32'(gnt), 32'(2'b10));
      tick();
      chk("early_drop", 32'(gnt), 32'(0));
      gap_then_grant('0);

      // Watchdog forced release and lockout
      do_reset();
      req = 2'b01;
      tick();
      chk("wd_gnt0", 32'(gnt), 32'(2'b01));
      sen_in[0] = 1'b0;
      req[1]    = 1'b1;
      for (int i = 1; i < TO; i++) begin
         tick();
         chk("wd_hold", 32'(gnt), 32'(2'b01));
         chk("wd_tmo0", 32'(timeout_stb), 32'(0));
      end
      tick();
      chk("wd_fall", 32'(gnt), 32'(0));
      chk("wd_stb",  32'(timeout_stb), 32'(1));
      chk("wd_busy", 32'(busy), 32'(1));
      rr_m = 1;
      gap_then_grant(2'b10);
      chk("wd_owner1", 32'(owner), 32'(1));
      len = $urandom_range(2, 8);
      run_txn(1, len);
      sen_in[0] = 1'b0;
      do_release(1);
      gap_then_grant('0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wd_locked", 32'(gnt), 32'(0));
      end
      req[0]    = 1'b0;
      sen_in[0] = 1'b1;
      tick();
      chk("wd_unlock_idle", 32'(gnt), 32'(0));
      req[0] = 1'b1;
      tick();
      chk("wd_regrant", 32'(gnt), 32'(2'b01));
      do_release(0);
      gap_then_grant('0);

      // Reset asserted mid-grant
      do_reset();
      req = 2'b10;
      tick();
      chk("rstmid_gnt", 32'(gnt), 32'(2'b10));
      sen_in  = 2'b00;
      sclk_in = 2'b11;
      mosi_in = 2'b11;
      tick();
      chk("rstmid_sclk_live", 32'(spi_sclk), 32'(1));
      bus_rst = 1'b1;
      tick();
      chk("rstmid_gnt0",  32'(gnt), 32'(0));
      chk("rstmid_sen",   32'(spi_sen), 32'(1));
      chk("rstmid_sclk",  32'(spi_sclk), 32'(0));
      chk("rstmid_busy",  32'(busy), 32'(0));
      chk("rstmid_owner", 32'(owner), 32'(0));
      bus_rst = 1'b0;
      req     = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
